tx_flow_ctrl_inserter: RTL and testbench

- Transmit-side counterpart of the link receive controller.
- Runs on frame-start strobes from the TX framer and selects the 18-bit frame code for each outgoing frame: user data, IDLE, PAUSE burst or RETRANS burst.
- Bursts are sized so the far-end receive controller reliably saturates its 8-deep PAUSE/RETRANS detection counters and its 16-deep regular-frame release counter.
- Sits between local RX flow-control/CRC logic (request sources) and the TX framer/scrambler.

---
 rtl/tx_flow_ctrl_inserter_if.sv | 33 +++
 rtl/tx_flow_ctrl_inserter.sv | 152 +++++++++++++++
 tb/tb_tx_flow_ctrl_inserter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_flow_ctrl_inserter_if.sv
// ============================================================================
// Module   : tx_flow_ctrl_inserter_if
// Brief    : Request/frame-code bundle between flow-control sources, the
//            frame-code inserter and the TX framer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface tx_flow_ctrl_inserter_if;
  logic        sof;
  logic        tx_aligned;
  logic        local_pause_req;
  logic        local_retrans_req;
  logic        data_valid;
  logic [17:0] code;
  logic        data_ready;
  logic        ctrl_busy;
  logic        retrans_pending;

  // Driver side: request sources and framer strobes
  modport master (
    output sof, tx_aligned, local_pause_req, local_retrans_req, data_valid,
    input  code, data_ready, ctrl_busy, retrans_pending
  );

  // Inserter side
  modport slave (
    input  sof, tx_aligned, local_pause_req, local_retrans_req, data_valid,
    output code, data_ready, ctrl_busy, retrans_pending
  );
endinterface

`default_nettype wire

// File: rtl/tx_flow_ctrl_inserter.sv
// ============================================================================
// Module   : tx_flow_ctrl_inserter
// Brief    : Picks the 18-bit frame code (data, IDLE, PAUSE or RETRANS burst)
//            for every TX frame slot announced by sof.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tx_flow_ctrl_inserter #(
  parameter int PAUSE_MIN   = 12,
  parameter int RETRANS_LEN = 12,
  parameter int RECOVER_LEN = 20
) (
  input  wire                     clk,
  input  wire                     rst_n,
  tx_flow_ctrl_inserter_if.slave  bus
);

  localparam logic [17:0] C_CODE_IDLE    = {2'b10, 16'h0001};
  localparam logic [17:0] C_CODE_PAUSE   = {2'b10, 16'h0010};
  localparam logic [17:0] C_CODE_RETRANS = {2'b10, 16'h1000};
  localparam logic [17:0] C_CODE_DATA    = {2'b01, 16'h0000};
  localparam logic [4:0]  C_PAUSE_MIN    = 5'(PAUSE_MIN);
  localparam logic [4:0]  C_RETRANS_LEN  = 5'(RETRANS_LEN);
  localparam logic [4:0]  C_RECOVER_LEN  = 5'(RECOVER_LEN);

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_PAUSE   = 2'd1,
    ST_RETRANS = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_cnt;
  logic [4:0]  w_cnt_nxt;
  logic [4:0]  w_cnt_inc;
  logic [17:0] r_code;
  logic [17:0] w_code_nxt;
  logic        r_data_ready;
  logic        w_data_ready_nxt;
  logic        r_ctrl_busy;
  logic        r_retrans_pending;
  logic        w_rtx_start;

  assign w_cnt_inc = (r_cnt == 5'd31) ? 5'd31 : r_cnt + 5'd1;

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_code_nxt       = r_code;
    w_data_ready_nxt = r_data_ready;
    w_rtx_start      = 1'b0;
    if (bus.sof) begin
      // Regular frame unless a burst decision below overrides it
      w_code_nxt       = bus.data_valid ? C_CODE_DATA : C_CODE_IDLE;
      w_data_ready_nxt = bus.data_valid;
      unique case (r_state)
        ST_PAUSE: begin
          if (r_retrans_pending) begin
            w_rtx_start = 1'b1;
          end else if (r_cnt < C_PAUSE_MIN || bus.local_pause_req) begin
            w_code_nxt       = C_CODE_PAUSE;
            w_data_ready_nxt = 1'b0;
            w_cnt_nxt        = w_cnt_inc;
          end else begin
            w_state_nxt = ST_RECOVER;
            w_cnt_nxt   = 5'd1;
          end
        end
        ST_RETRANS: begin
          if (r_cnt < C_RETRANS_LEN) begin
            w_code_nxt       = C_CODE_RETRANS;
            w_data_ready_nxt = 1'b0;
            w_cnt_nxt        = w_cnt_inc;
          end else if (r_retrans_pending) begin
            w_rtx_start = 1'b1;
          end else if (bus.local_pause_req) begin
            w_state_nxt      = ST_PAUSE;
            w_code_nxt       = C_CODE_PAUSE;
            w_data_ready_nxt = 1'b0;
            w_cnt_nxt        = 5'd1;
          end else begin
            w_state_nxt = ST_RECOVER;
            w_cnt_nxt   = 5'd1;
          end
        end
        default: begin
          // NORMAL, and RECOVER which shares its burst-entry priority
          if (r_retrans_pending) begin
            w_rtx_start = 1'b1;
          end else if (bus.local_pause_req) begin
            w_state_nxt      = ST_PAUSE;
            w_code_nxt       = C_CODE_PAUSE;
            w_data_ready_nxt = 1'b0;
            w_cnt_nxt        = 5'd1;
          end else if (r_state == ST_RECOVER && r_cnt < C_RECOVER_LEN) begin
            w_cnt_nxt = w_cnt_inc;
          end else begin
            w_state_nxt = ST_NORMAL;
            w_cnt_nxt   = 5'd0;
          end
        end
      endcase
      if (w_rtx_start) begin
        w_state_nxt      = ST_RETRANS;
        w_code_nxt       = C_CODE_RETRANS;
        w_data_ready_nxt = 1'b0;
        w_cnt_nxt        = 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= ST_NORMAL;
      r_cnt             <= 5'd0;
      r_code            <= C_CODE_IDLE;
      r_data_ready      <= 1'b0;
      r_ctrl_busy       <= 1'b0;
      r_retrans_pending <= 1'b0;
    end else if (!bus.tx_aligned) begin
      r_state           <= ST_NORMAL;
      r_cnt             <= 5'd0;
      r_code            <= C_CODE_IDLE;
      r_data_ready      <= 1'b0;
      r_ctrl_busy       <= 1'b0;
      r_retrans_pending <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_code       <= w_code_nxt;
      r_data_ready <= w_data_ready_nxt;
      r_ctrl_busy  <= (w_state_nxt != ST_NORMAL);
      // A new request wins over the clear so a coincident pulse is not lost
      if (bus.local_retrans_req) begin
        r_retrans_pending <= 1'b1;
      end else if (w_rtx_start) begin
        r_retrans_pending <= 1'b0;
      end
    end
  end

  assign bus.code            = r_code;
  assign bus.data_ready      = r_data_ready;
  assign bus.ctrl_busy       = r_ctrl_busy;
  assign bus.retrans_pending = r_retrans_pending;

endmodule

`default_nettype wire

// File: tb/tb_tx_flow_ctrl_inserter.sv
// ============================================================================
// Module   : tb_tx_flow_ctrl_inserter
// Brief    : Directed self-checking bench for tx_flow_ctrl_inserter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tx_flow_ctrl_inserter;

  localparam logic [17:0] C_IDLE  = {2'b10, 16'h0001};
  localparam logic [17:0] C_PAUSE = {2'b10, 16'h0010};
  localparam logic [17:0] C_RTX   = {2'b10, 16'h1000};
  localparam logic [17:0] C_DATA  = {2'b01, 16'h0000};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  tx_flow_ctrl_inserter_if bus ();

  tx_flow_ctrl_inserter #(
    .PAUSE_MIN   (12),
    .RETRANS_LEN (12),
    .RECOVER_LEN (20)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Observed vector: {code, data_ready, ctrl_busy, retrans_pending}
  logic [20:0] obs;
  assign obs = {bus.code, bus.data_ready, bus.ctrl_busy, bus.retrans_pending};

  task automatic frame();
    repeat (2) @(negedge clk);
    bus.sof = 1'b1;
    @(negedge clk);
    bus.sof = 1'b0;
  endtask

  task automatic pulse_rtx();
    @(negedge clk);
    bus.local_retrans_req = 1'b1;
    @(negedge clk);
    bus.local_retrans_req = 1'b0;
  endtask

  task automatic flush();
    bus.local_pause_req = 1'b0;
    bus.data_valid      = 1'b0;
    @(negedge clk);
    bus.tx_aligned = 1'b0;
    @(negedge clk);
    bus.tx_aligned = 1'b1;
  endtask

  task automatic test_reset();
    logic [20:0] exp;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp = {C_IDLE, 1'b0, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp) $display("FAIL reset_init: got %h expected %h", obs, exp);
    else n_pass++;

    bus.local_pause_req = 1'b1;
    frame();
    bus.local_pause_req = 1'b0;
    pulse_rtx();
    exp = {C_PAUSE, 1'b0, 1'b1, 1'b1};
    n_checks++;
    if (obs !== exp) $display("FAIL pre_reset_busy: got %h expected %h", obs, exp);
    else n_pass++;

    // Reset asserted between edges must take effect without a clock edge
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp = {C_IDLE, 1'b0, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp) $display("FAIL async_reset: got %h expected %h", obs, exp);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle_data();
    logic [20:0] exp;
    bus.data_valid = 1'b0;
    frame();
    exp = {C_IDLE, 1'b0, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp) $display("FAIL idle_frame: got %h expected %h", obs, exp);
    else n_pass++;
    bus.data_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      frame();
      exp = {C_DATA, 1'b1, 1'b0, 1'b0};
      n_checks++;
      if (obs !== exp) $display("FAIL data_frame %0d: got %h expected %h", i, obs, exp);
      else n_pass++;
    end
  endtask

  task automatic test_short_pause();
    logic [20:0] exp;
    bus.data_valid = 1'b1;
    for (int i = 0; i <= 32; i++) begin
      bus.local_pause_req = (i == 0 || i == 5);
      frame();
      if (i < 12)      exp = {C_PAUSE, 1'b0, 1'b1, 1'b0};
      else if (i < 32) exp = {C_DATA, 1'b1, 1'b1, 1'b0};
      else             exp = {C_DATA, 1'b1, 1'b0, 1'b0};
      n_checks++;
      if (obs !== exp) $display("FAIL short_pause frame %0d: got %h expected %h", i, obs, exp);
      else n_pass++;
    end
    bus.local_pause_req = 1'b0;
  endtask

  task automatic test_long_pause();
    logic [20:0] exp;
    bus.data_valid = 1'b1;
    for (int i = 0; i <= 50; i++) begin
      bus.local_pause_req = (i < 30);
      frame();
      if (i < 30)      exp = {C_PAUSE, 1'b0, 1'b1, 1'b0};
      else if (i < 50) exp = {C_DATA, 1'b1, 1'b1, 1'b0};
      else             exp = {C_DATA, 1'b1, 1'b0, 1'b0};
      n_checks++;
      if (obs !== exp) $display("FAIL long_pause frame %0d: got %h expected %h", i, obs, exp);
      else n_pass++;
    end
    bus.local_pause_req = 1'b0;
  endtask

  task automatic test_retrans_preempt();
    logic [20:0] exp;
    bus.data_valid      = 1'b0;
    bus.local_pause_req = 1'b1;
    for (int i = 0; i <= 29; i++) begin
      frame();
      if (i == 4) pulse_rtx();
      if (i == 17) bus.local_pause_req = 1'b0;
      if (i < 5)       exp = {C_PAUSE, 1'b0, 1'b1, (i == 4)};
      else if (i < 17) exp = {C_RTX, 1'b0, 1'b1, 1'b0};
      else if (i < 29) exp = {C_PAUSE, 1'b0, 1'b1, 1'b0};
      else             exp = {C_IDLE, 1'b0, 1'b1, 1'b0};
      n_checks++;
      if (obs !== exp) $display("FAIL preempt frame %0d: got %h expected %h", i, obs, exp);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [20:0] exp;
    bus.data_valid      = 1'b0;
    bus.local_pause_req = 1'b0;
    pulse_rtx();
    exp = {C_IDLE, 1'b0, 1'b0, 1'b1};
    n_checks++;
    if (obs !== exp) $display("FAIL b2b_pending_set: got %h expected %h", obs, exp);
    else n_pass++;
    for (int i = 0; i <= 24; i++) begin
      frame();
      if (i == 3) pulse_rtx();
      if (i < 24) exp = {C_RTX, 1'b0, 1'b1, (i >= 3 && i < 12)};
      else        exp = {C_IDLE, 1'b0, 1'b1, 1'b0};
      n_checks++;
      if (obs !== exp) $display("FAIL b2b frame %0d: got %h expected %h", i, obs, exp);
      else n_pass++;
    end
  endtask

  task automatic test_alignment();
    logic [20:0] exp;
    bus.data_valid = 1'b0;
    pulse_rtx();
    for (int i = 0; i < 7; i++) begin
      frame();
      exp = {C_RTX, 1'b0, 1'b1, 1'b0};
      n_checks++;
      if (obs !== exp) $display("FAIL align_rtx frame %0d: got %h expected %h", i, obs, exp);
      else n_pass++;
    end
    pulse_rtx();
    exp = {C_RTX, 1'b0, 1'b1, 1'b1};
    n_checks++;
    if (obs !== exp) $display("FAIL align_pending: got %h expected %h", obs, exp);
    else n_pass++;

    @(negedge clk);
    bus.tx_aligned = 1'b0;
    @(negedge clk);
    exp = {C_IDLE, 1'b0, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp) $display("FAIL align_loss: got %h expected %h", obs, exp);
    else n_pass++;

    // Retransmit requests and frame strobes are ignored while unaligned
    pulse_rtx();
    bus.data_valid = 1'b1;
    frame();
    n_checks++;
    if (obs !== exp) $display("FAIL align_hold: got %h expected %h", obs, exp);
    else n_pass++;

    bus.tx_aligned = 1'b1;
    for (int i = 0; i < 3; i++) begin
      frame();
      exp = {C_DATA, 1'b1, 1'b0, 1'b0};
      n_checks++;
      if (obs !== exp) $display("FAIL realign frame %0d: got %h expected %h", i, obs, exp);
      else n_pass++;
    end
  endtask

  initial begin
    bus.sof               = 1'b0;
    bus.tx_aligned        = 1'b1;
    bus.local_pause_req   = 1'b0;
    bus.local_retrans_req = 1'b0;
    bus.data_valid        = 1'b0;
    test_reset();
    test_idle_data();
    test_short_pause();
    test_long_pause();
    test_retrans_preempt();
    flush();
    test_back_to_back();
    flush();
    test_alignment();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
